// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: control bundle layout, forward selects and
// the register-index helpers used by the ID/EX stage and its hazard logic.
package mips_pipe_pkg;

  localparam int CTRL_W = 12;

  // Bit positions inside {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst[1:0], Branch, ALUOp[3:0]}
  localparam int CTRL_REGWRITE = 11;
  localparam int CTRL_MEMREAD  = 10;
  localparam int CTRL_MEMWRITE = 9;
  localparam int CTRL_MEMTOREG = 8;
  localparam int CTRL_ALUSRC   = 7;
  localparam int CTRL_REGDST_HI = 6;
  localparam int CTRL_REGDST_LO = 5;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_ALUOP_HI = 3;
  localparam int CTRL_ALUOP_LO = 0;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 12'h000;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_EXM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a write port targets a real (non-$0) register matching idx.
  function automatic logic wr_hit(input logic we, input logic [4:0] wr_rd,
                                  input logic [4:0] idx);
    return we && (wr_rd != REG_ZERO) && (wr_rd == idx);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use hazard detection and EX-stage forwarding selects,
// evaluated against the current ID/EX latch contents.
module hazard_fwd_unit
  import mips_pipe_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       exm_we,
  input  logic [4:0] exm_rd,
  input  logic       wb_we,
  input  logic [4:0] wb_rd,
  output logic       hz,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  // Hazard and forward-select decode; bubbles never forward.
  always_comb begin
    hz    = 1'b0;
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (ex_valid) begin
      hz = ex_memread && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
      if (wr_hit(exm_we, exm_rd, ex_rs)) begin
        fwd_a = FWD_EXM;
      end else if (wr_hit(wb_we, wb_rd, ex_rs)) begin
        fwd_a = FWD_WB;
      end else begin
        fwd_a = FWD_RF;
      end
      if (wr_hit(exm_we, exm_rd, ex_rt)) begin
        fwd_b = FWD_EXM;
      end else if (wr_hit(wb_we, wb_rd, ex_rt)) begin
        fwd_b = FWD_WB;
      end else begin
        fwd_b = FWD_RF;
      end
    end else begin
      hz    = 1'b0;
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline latch with writeback bypass, load-use bubble insertion,
// branch flush and a saturating stall counter.
module id_ex_stage
  import mips_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [31:0]       id_imm,
  input  logic [31:0]       id_pc4,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       rf_data1,
  input  logic [31:0]       rf_data2,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [31:0]       wb_data,
  input  logic              exm_we,
  input  logic [4:0]        exm_rd,
  input  logic              flush,
  output logic              stall_o,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_op1,
  output logic [31:0]       ex_op2,
  output logic [31:0]       ex_imm,
  output logic [31:0]       ex_pc4,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [15:0]       stall_cnt
);

  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [31:0]       op1_d, op1_q, op2_d, op2_q, imm_d, imm_q, pc4_d, pc4_q;
  logic [4:0]        rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
  logic [15:0]       stall_cnt_d, stall_cnt_q;
  logic [31:0]       byp1_s, byp2_s;
  logic              hz_s;

  hazard_fwd_unit u_hfu (
    .ex_valid  (valid_q),
    .ex_memread(ctrl_q[CTRL_MEMREAD]),
    .ex_rs     (rs_q),
    .ex_rt     (rt_q),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .exm_we    (exm_we),
    .exm_rd    (exm_rd),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .hz        (hz_s),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b)
  );

  // $0 always reads as zero; otherwise a same-cycle writeback wins over the RF.
  always_comb begin
    byp1_s = 32'h0;
    byp2_s = 32'h0;
    if (id_rs == REG_ZERO) byp1_s = 32'h0;
    else if (wr_hit(wb_we, wb_rd, id_rs)) byp1_s = wb_data;
    else byp1_s = rf_data1;
    if (id_rt == REG_ZERO) byp2_s = 32'h0;
    else if (wr_hit(wb_we, wb_rd, id_rt)) byp2_s = wb_data;
    else byp2_s = rf_data2;
  end

  // Next latch contents: flush beats load-use, both insert an all-zero bubble.
  always_comb begin
    valid_d     = 1'b0;
    ctrl_d      = CTRL_BUBBLE;
    op1_d       = 32'h0;
    op2_d       = 32'h0;
    imm_d       = 32'h0;
    pc4_d       = 32'h0;
    rs_d        = REG_ZERO;
    rt_d        = REG_ZERO;
    rd_d        = REG_ZERO;
    stall_cnt_d = stall_cnt_q;
    stall_o     = 1'b0;
    if (flush) begin
      stall_o = 1'b0;
    end else if (hz_s) begin
      stall_o = 1'b1;
      if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      else stall_cnt_d = stall_cnt_q;
    end else begin
      valid_d = 1'b1;
      ctrl_d  = id_ctrl;
      op1_d   = byp1_s;
      op2_d   = byp2_s;
      imm_d   = id_imm;
      pc4_d   = id_pc4;
      rs_d    = id_rs;
      rt_d    = id_rt;
      rd_d    = id_rd;
    end
  end

  // ID/EX latch and stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      ctrl_q      <= CTRL_BUBBLE;
      op1_q       <= 32'h0;
      op2_q       <= 32'h0;
      imm_q       <= 32'h0;
      pc4_q       <= 32'h0;
      rs_q        <= REG_ZERO;
      rt_q        <= REG_ZERO;
      rd_q        <= REG_ZERO;
      stall_cnt_q <= 16'h0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      imm_q       <= imm_d;
      pc4_q       <= pc4_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid  = valid_q;
  assign ex_ctrl   = ctrl_q;
  assign ex_op1    = op1_q;
  assign ex_op2    = op2_q;
  assign ex_imm    = imm_q;
  assign ex_pc4    = pc4_q;
  assign ex_rs     = rs_q;
  assign ex_rt     = rt_q;
  assign ex_rd     = rd_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage for the 5-stage MIPS core. It consumes the two combinational read ports of the register file, bypasses a same-cycle writeback, and registers operands, immediate, register indices and control into the ID/EX latch. It also detects load-use hazards (stall plus bubble), applies branch flushes, and drives EX-stage forwarding selects.

## Interface
- No parameters. Widths fixed: data 32, register index 5, ALUOp 4, RegDst 2.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-low; all state cleared while low.
- `id_rs`, `id_rt`, `id_rd` in 5 each: IF/ID instruction register fields.
- `id_imm` in 32: sign/zero-extended immediate.
- `id_pc4` in 32: PC+4 of the decoding instruction.
- `id_ctrl` in 12: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst[1:0], Branch, ALUOp[3:0]}.
- `rf_data1`, `rf_data2` in 32: register file read ports (rs, rt).
- `wb_we`, `wb_rd`, `wb_data` in 1/5/32: MEM/WB write port, same signals driving the register file.
- `exm_we`, `exm_rd` in 1/5: EX/MEM destination.
- `flush` in 1: branch/jump resolved taken in EX; squash the ID instruction.
- `stall_o` out 1: hold PC and IF/ID this cycle.
- `ex_valid` out 1; `ex_ctrl` out 12; `ex_op1`, `ex_op2`, `ex_imm`, `ex_pc4` out 32; `ex_rs`, `ex_rt`, `ex_rd` out 5: ID/EX latch.
- `fwd_a`, `fwd_b` out 2: EX operand select (00 latch, 01 MEM/WB, 10 EX/MEM).
- `stall_cnt` out 16: saturating count of load-use stall cycles.

## Operation
- ID bypass: if `wb_we` && `wb_rd != 0` && `wb_rd == id_rs`, op1 = `wb_data`, else `rf_data1`; same for rt/op2. Index 0 reads as 0 regardless.
- Load-use hazard (`hz`): `ex_valid` && `ex_ctrl.MemRead` && `ex_rt != 0` && (`ex_rt == id_rs` || `ex_rt == id_rt`).
- Per-cycle latch action, priority order:
  - `flush`: load bubble (`ex_valid`=0, `ex_ctrl`=0, indices 0, data 0); `stall_o`=0.
  - else `hz`: load bubble; `stall_o`=1; `stall_cnt` += 1, saturating at 16'hFFFF.
  - else: load ID fields, operands after bypass, `ex_valid`=1.
- `stall_o` is combinational from `hz` and `flush`; never asserted during flush.
- Forwarding (combinational from latch): `fwd_a`=10 if `exm_we` && `exm_rd != 0` && `exm_rd == ex_rs`; else 01 if `wb_we` && `wb_rd != 0` && `wb_rd == ex_rs`; else 00. `fwd_b` identically on `ex_rt`. EX/MEM beats MEM/WB. Both are 00 when `ex_valid`=0.
- Bubble control is all zeros: no RegWrite, no MemWrite, no Branch.

## Timing
- Latency 1 cycle: ID inputs at edge N appear on `ex_*` after edge N.
- `reset` low: all outputs 0 (`ex_valid`=0, `stall_cnt`=0, `fwd_*`=00, `stall_o`=0), asynchronously. Release is effective at the next edge.
- Reset asserted mid-stall: bubble state discarded; next instruction presented is latched normally.
- A load-use stall lasts exactly one cycle. After the bubble, `ex_valid`=0 and `hz` drops.
- Back-to-back: load then dependent instruction gives one bubble; the dependent instruction then receives the loaded value via `fwd`=01.
- Simultaneous `flush` and `hz`: flush wins, no stall, counter unchanged.

## Structure
- Shared package `mips_pipe_pkg`:
  - control bundle field offsets, width 12, and `CTRL_BUBBLE`=0;
  - forward-select constants `FWD_RF`, `FWD_WB`, `FWD_EXM`;
  - `REG_ZERO`=5'd0.
- One sub-module, `hazard_fwd_unit`: purely combinational `hz`, `fwd_a`, `fwd_b`. The latch, bypass and counter stay in `id_ex_stage`.

## Test plan
- Reset: drive `reset`=0 mid-traffic → all outputs 0 within the same cycle, `stall_cnt`=0.
- WB bypass: `rf_data1`=0x1111, `wb_we`=1, `wb_rd`=`id_rs`=5, `wb_data`=0xABCD → `ex_op1`=0xABCD next cycle. Repeat with `wb_rd`=0, `id_rs`=0 → `ex_op1`=0.
- Load-use: lw $8 latched (MemRead, `ex_rt`=8), then add with `id_rs`=8 → `stall_o`=1 one cycle, bubble latched, `stall_cnt`=1. Next cycle the add is latched with `stall_o`=0.
- Forward priority: `ex_rs`=3, `exm_we`=1/`exm_rd`=3, `wb_we`=1/`wb_rd`=3 → `fwd_a`=10. Drop `exm_we` → `fwd_a`=01.
- Flush vs stall: load-use condition plus `flush`=1 → `stall_o`=0, bubble latched, `stall_cnt` unchanged.
- Saturation: force 65 540 stall cycles → `stall_cnt` holds 16'hFFFF.
